// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared WS2812 timing constants at a 12 MHz system clock and
//                the receiver state encoding. Used by ws2812_output and
//                ws2812_input so both ends of a loopback agree on timing.
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Line timing in 12 MHz clock cycles
    localparam int c_T0H_CYCLES   = 5;    // ~0.40 us high for a 0 bit
    localparam int c_T1H_CYCLES   = 10;   // ~0.80 us high for a 1 bit
    localparam int c_BIT_CYCLES   = 15;   // ~1.25 us per bit
    localparam int c_LATCH_CYCLES = 600;  // 50 us low latch gap

    // Receiver decode limits derived from the line timing: the 1/0 decision
    // sits midway between T0H and T1H, and no legal high outlasts a bit period.
    localparam int c_RX_THRESHOLD = (c_T0H_CYCLES + c_T1H_CYCLES) / 2;
    localparam int c_RX_MIN_HIGH  = 2;
    localparam int c_RX_MAX_HIGH  = c_BIT_CYCLES;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } rx_state_t;

endpackage : ws2812_pkg
`default_nettype wire

// File: rtl/ws2812_input_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for an asynchronous pin plus a
//                registered copy of the synchronized value for edge detect.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_async      - asynchronous input pin
//                o_sync       - synchronized value (2 cycles latency)
//                o_prev       - o_sync delayed by one cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_prev
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_prev = r_prev;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/ws2812_input.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_input
//  Description : WS2812 serial-line receiver. Classifies each high pulse by
//                width as a 0/1 bit, assembles MSB-first bytes, strobes each
//                byte with its index in the frame, and flags latch gaps.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                din          - asynchronous WS2812 data line
//                data         - last completed byte
//                data_valid   - one-cycle strobe for data/byte_index
//                byte_index   - position of data in the current frame
//                frame_end    - one-cycle pulse on a completed latch gap
//                error        - one-cycle pulse on a bad pulse/short byte
//                synced       - high while aligned to frames
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_input
    import ws2812_pkg::*;
#(
    parameter int THRESHOLD_CYCLES = c_RX_THRESHOLD,
    parameter int MIN_HIGH         = c_RX_MIN_HIGH,
    parameter int MAX_HIGH         = c_RX_MAX_HIGH,
    parameter int RESET_CYCLES     = c_LATCH_CYCLES,
    parameter int IDX_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [7:0]       data,
    output logic             data_valid,
    output logic [IDX_W-1:0] byte_index,
    output logic             frame_end,
    output logic             error,
    output logic             synced
);

    localparam int c_LCNT_W = $clog2(RESET_CYCLES + 1);
    localparam int c_HCNT_W = $clog2(MAX_HIGH + 2);

    localparam logic [c_LCNT_W-1:0] c_RESET    = c_LCNT_W'(RESET_CYCLES);
    localparam logic [c_LCNT_W-1:0] c_RESET_M1 = c_LCNT_W'(RESET_CYCLES - 1);
    localparam logic [c_HCNT_W-1:0] c_THRESH   = c_HCNT_W'(THRESHOLD_CYCLES);
    localparam logic [c_HCNT_W-1:0] c_MIN_HIGH = c_HCNT_W'(MIN_HIGH);
    localparam logic [c_HCNT_W-1:0] c_MAX_HIGH = c_HCNT_W'(MAX_HIGH);
    localparam logic [c_HCNT_W-1:0] c_HCNT_ONE = c_HCNT_W'(1);
    localparam logic [c_LCNT_W-1:0] c_LCNT_ONE = c_LCNT_W'(1);
    localparam logic [IDX_W-1:0]    c_IDX_MAX  = {IDX_W{1'b1}};

    logic w_din_s;
    logic w_din_prev;
    logic w_rise;
    logic w_fall;
    logic w_bit;

    rx_state_t           r_state;
    logic [c_LCNT_W-1:0] r_scnt;
    logic [c_LCNT_W-1:0] r_lcnt;
    logic [c_HCNT_W-1:0] r_hcnt;
    logic [3:0]          r_bitcnt;
    logic [7:0]          r_shreg;
    logic [7:0]          r_data;
    logic                r_data_valid;
    logic [IDX_W-1:0]    r_byte_index;
    logic                r_idx_inc;
    logic                r_frame_end;
    logic                r_error;
    logic                r_synced;

    sync_2ff u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (din),
        .o_sync  (w_din_s),
        .o_prev  (w_din_prev)
    );

    assign w_rise = w_din_s & ~w_din_prev;
    assign w_fall = ~w_din_s & w_din_prev;
    assign w_bit  = (r_hcnt >= c_THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SYNC;
            r_scnt       <= '0;
            r_lcnt       <= '0;
            r_hcnt       <= '0;
            r_bitcnt     <= '0;
            r_shreg      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_byte_index <= '0;
            r_idx_inc    <= 1'b0;
            r_frame_end  <= 1'b0;
            r_error      <= 1'b0;
            r_synced     <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_end  <= 1'b0;
            r_error      <= 1'b0;
            r_idx_inc    <= 1'b0;

            // The index advances the cycle after a strobe so the strobe
            // carries the index of the byte it delivers.
            if (r_idx_inc && (r_byte_index != c_IDX_MAX)) begin
                r_byte_index <= r_byte_index + 1'b1;
            end

            // A full byte is delivered one cycle after its eighth falling edge.
            // That cycle is always in LOW, which never touches bitcnt itself.
            if (r_bitcnt == 4'd8) begin
                r_data       <= r_shreg;
                r_data_valid <= 1'b1;
                r_bitcnt     <= '0;
                r_idx_inc    <= 1'b1;
            end

            case (r_state)
                ST_SYNC: begin
                    if (w_din_s) begin
                        r_scnt <= '0;
                    end else if (r_scnt == c_RESET_M1) begin
                        r_scnt   <= '0;
                        r_state  <= ST_IDLE;
                        r_synced <= 1'b1;
                    end else begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (w_rise) begin
                        r_hcnt  <= c_HCNT_ONE;
                        r_state <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    // Overlong high is checked first so it also catches a
                    // falling edge arriving right after hcnt saturated.
                    if ((r_hcnt > c_MAX_HIGH) || (w_fall && (r_hcnt < c_MIN_HIGH))) begin
                        r_error      <= 1'b1;
                        r_state      <= ST_SYNC;
                        r_synced     <= 1'b0;
                        r_scnt       <= '0;
                        r_bitcnt     <= '0;
                        r_byte_index <= '0;
                        r_idx_inc    <= 1'b0;
                    end else if (w_fall) begin
                        r_shreg  <= {r_shreg[6:0], w_bit};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_lcnt   <= c_LCNT_ONE;
                        r_state  <= ST_LOW;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end

                ST_LOW: begin
                    if (w_rise) begin
                        r_hcnt  <= c_HCNT_ONE;
                        r_state <= ST_HIGH;
                    end else if (r_lcnt == c_RESET) begin
                        r_frame_end  <= 1'b1;
                        r_error      <= (r_bitcnt != 4'd0);
                        r_bitcnt     <= '0;
                        r_byte_index <= '0;
                        r_idx_inc    <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end

                default: begin
                    r_state  <= ST_SYNC;
                    r_synced <= 1'b0;
                end
            endcase
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign byte_index = r_byte_index;
    assign frame_end  = r_frame_end;
    assign error      = r_error;
    assign synced     = r_synced;

endmodule : ws2812_input
`default_nettype wire

// File: tb/tb_ws2812_input.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_input
//  Description : Directed self-checking bench for ws2812_input. Drives the
//                WS2812 line with hand-built pulse trains and compares the
//                decoded bytes, indices, frame ends and errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_input;

    localparam int c_RESET = 600;

    logic        clk;
    logic        rst;
    logic        din;
    logic [7:0]  data;
    logic        data_valid;
    logic [15:0] byte_index;
    logic        frame_end;
    logic        error;
    logic        synced;

    ws2812_input dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .data       (data),
        .data_valid (data_valid),
        .byte_index (byte_index),
        .frame_end  (frame_end),
        .error      (error),
        .synced     (synced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Event log collected on the falling clock edge
    logic [7:0] q_data[$];
    int         q_idx[$];
    int         n_dv      = 0;
    int         n_fe      = 0;
    int         n_err     = 0;
    int         n_fe_err  = 0;
    int         n_overlap = 0;

    always @(negedge clk) begin
        if (data_valid) begin
            q_data.push_back(data);
            q_idx.push_back(int'(byte_index));
            n_dv++;
        end
        if (frame_end)                n_fe++;
        if (error)                    n_err++;
        if (frame_end && error)       n_fe_err++;
        if (frame_end && data_valid)  n_overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] v, input int nbits,
                             input int h0, input int h1, input int per);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (v[i]) send_pulse(h1, per - h1);
            else      send_pulse(h0, per - h0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits({8'h00, b}, 8, 5, 10, 15);
    endtask

    task automatic idle_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    int b_dv, b_fe, b_err, b_fe_err;
    int lat_dv, lat_fe;

    task automatic mark();
        b_dv     = n_dv;
        b_fe     = n_fe;
        b_err    = n_err;
        b_fe_err = n_fe_err;
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_data",  32'(data),       32'h00);
        check_eq("rst_dv",    32'(data_valid), 32'h0);
        check_eq("rst_idx",   32'(byte_index), 32'h0);
        check_eq("rst_fe",    32'(frame_end),  32'h0);
        check_eq("rst_err",   32'(error),      32'h0);
        check_eq("rst_sync",  32'(synced),     32'h0);
        rst = 1'b0;

        // Initial alignment: not synced before the latch, synced after it
        idle_low(300);
        check_eq("presync", 32'(synced), 32'h0);
        idle_low(310);
        check_eq("sync_up", 32'(synced), 32'h1);
        check_eq("sync_no_fe", 32'(n_fe), 32'h0);

        // Three-byte frame with nominal timing
        mark();
        send_byte(8'hAC);
        send_byte(8'h55);
        send_byte(8'h0F);
        idle_low(650);
        check_eq("f1_dv_cnt", 32'(n_dv - b_dv), 32'd3);
        if (n_dv - b_dv == 3) begin
            check_eq("f1_b0", 32'(q_data[b_dv]),     32'hAC);
            check_eq("f1_b1", 32'(q_data[b_dv + 1]), 32'h55);
            check_eq("f1_b2", 32'(q_data[b_dv + 2]), 32'h0F);
            check_eq("f1_i0", 32'(q_idx[b_dv]),      32'd0);
            check_eq("f1_i1", 32'(q_idx[b_dv + 1]),  32'd1);
            check_eq("f1_i2", 32'(q_idx[b_dv + 2]),  32'd2);
        end
        check_eq("f1_fe",  32'(n_fe - b_fe),   32'd1);
        check_eq("f1_err", 32'(n_err - b_err), 32'd0);

        // Threshold boundary: 6-cycle high is a 0, 7-cycle high is a 1.
        // The last bit is sent by hand to measure strobe and latch latency.
        mark();
        send_bits(16'h002A, 7, 6, 7, 15);
        din = 1'b1;
        repeat (7) @(negedge clk);
        din = 1'b0;
        lat_dv = 0;
        lat_fe = 0;
        for (int i = 1; i <= 800 && lat_fe == 0; i++) begin
            @(negedge clk);
            if (data_valid && lat_dv == 0) lat_dv = i;
            if (frame_end) lat_fe = i;
        end
        check_eq("thr_dv_lat", 32'(lat_dv), 32'd4);
        check_eq("thr_fe_lat_ok",
                 32'((lat_fe >= c_RESET + 2) && (lat_fe <= c_RESET + 4)), 32'd1);
        idle_low(10);
        check_eq("thr_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        if (n_dv - b_dv == 1) begin
            check_eq("thr_data", 32'(q_data[b_dv]), 32'h55);
            check_eq("thr_idx",  32'(q_idx[b_dv]),  32'd0);
        end
        check_eq("thr_err", 32'(n_err - b_err), 32'd0);

        // One-cycle glitch mid-byte
        mark();
        send_bits(16'h0005, 3, 5, 10, 15);
        send_pulse(1, 10);
        check_eq("gl_err",  32'(n_err - b_err), 32'd1);
        check_eq("gl_sync", 32'(synced),        32'h0);
        send_bits(16'h00FF, 8, 5, 10, 15);
        idle_low(200);
        check_eq("gl_no_dv", 32'(n_dv - b_dv), 32'd0);
        idle_low(420);
        check_eq("gl_resync", 32'(synced), 32'h1);
        check_eq("gl_no_fe",  32'(n_fe - b_fe), 32'd0);
        send_byte(8'h3C);
        idle_low(650);
        check_eq("gl_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        if (n_dv - b_dv == 1) begin
            check_eq("gl_data", 32'(q_data[b_dv]), 32'h3C);
            check_eq("gl_idx",  32'(q_idx[b_dv]),  32'd0);
        end

        // Overlong high: 20 cycles
        mark();
        send_pulse(20, 10);
        check_eq("ol_err",  32'(n_err - b_err), 32'd1);
        check_eq("ol_sync", 32'(synced),        32'h0);
        idle_low(620);
        check_eq("ol_resync", 32'(synced), 32'h1);

        // 12-bit frame: one byte plus a truncated nibble before the latch
        mark();
        send_byte(8'hA5);
        send_bits(16'h000A, 4, 5, 10, 15);
        idle_low(650);
        check_eq("tr_dv_cnt", 32'(n_dv - b_dv), 32'd1);
        if (n_dv - b_dv == 1) begin
            check_eq("tr_data", 32'(q_data[b_dv]), 32'hA5);
        end
        check_eq("tr_fe",     32'(n_fe - b_fe),         32'd1);
        check_eq("tr_fe_err", 32'(n_fe_err - b_fe_err), 32'd1);
        check_eq("tr_err",    32'(n_err - b_err),       32'd1);

        // Reset mid-byte, released mid-frame
        mark();
        send_bits(16'h0001, 4, 5, 10, 15);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rs_sync", 32'(synced),     32'h0);
        check_eq("rs_idx",  32'(byte_index), 32'h0);
        send_bits(16'h0002, 4, 5, 10, 15);
        send_byte(8'h34);
        idle_low(650);
        check_eq("rs_no_dv", 32'(n_dv - b_dv), 32'd0);
        check_eq("rs_no_fe", 32'(n_fe - b_fe), 32'd0);
        check_eq("rs_sync2", 32'(synced),      32'h1);
        send_byte(8'h9E);
        send_byte(8'h01);
        idle_low(650);
        check_eq("rs_dv_cnt", 32'(n_dv - b_dv), 32'd2);
        if (n_dv - b_dv == 2) begin
            check_eq("rs_b0", 32'(q_data[b_dv]),     32'h9E);
            check_eq("rs_b1", 32'(q_data[b_dv + 1]), 32'h01);
            check_eq("rs_i0", 32'(q_idx[b_dv]),      32'd0);
            check_eq("rs_i1", 32'(q_idx[b_dv + 1]),  32'd1);
        end
        check_eq("rs_fe", 32'(n_fe - b_fe), 32'd1);

        check_eq("no_overlap", 32'(n_overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_ws2812_input
`default_nettype wire

// File: doc/ws2812_input.md
# ws2812_input

WS2812 serial-line receiver: samples a single-wire WS2812 data stream, classifies each high pulse as a 0 or 1 bit by its width, and assembles MSB-first bits into bytes. Each byte is emitted with a one-cycle strobe and its position in the frame. A latch/reset gap is reported as a frame end. It is the receiving counterpart of `ws2812_output`; it sits on board input pins for strip loopback self-test and for chaining boards, feeding byte consumers in the same `clk` domain.

## Interface
Parameters:
- `THRESHOLD_CYCLES`, default 7: a high time ≥ this many cycles decodes as 1; a shorter one decodes as 0.
- `MIN_HIGH`, default 2: a high time < this is a glitch and counts as an error.
- `MAX_HIGH`, default 15: a high time > this is an error.
- `RESET_CYCLES`, default 600: consecutive low cycles that constitute a latch (50 µs at 12 MHz).
- `IDX_W`, default 16: width of `byte_index`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous active-high reset.
- `din`, in, 1: asynchronous WS2812 data line.
- `data`, out, 8: last completed byte.
- `data_valid`, out, 1: one-cycle strobe; `data` and `byte_index` are valid while it is high.
- `byte_index`, out, IDX_W: index of `data` within the current frame, starting at 0.
- `frame_end`, out, 1: one-cycle pulse when a latch gap completes a frame.
- `error`, out, 1: one-cycle pulse on a malformed pulse or a truncated byte.
- `synced`, out, 1: high while the receiver is aligned to frames (not in SYNC).

## Operation
- `din` passes through a 2-FF synchronizer, giving `din_s`. Edges are detected against a registered copy of `din_s`.
- States:
  - SYNC:
    - Count consecutive low cycles of `din_s`; any high clears the count.
    - When the count reaches RESET_CYCLES, go to IDLE. No `frame_end` is issued from SYNC.
  - IDLE: on a rising edge, go to HIGH with `hcnt` = 1.
  - HIGH:
    - `hcnt` increments each high cycle, saturating at MAX_HIGH+1.
    - If `hcnt` exceeds MAX_HIGH: pulse `error`, discard the partial byte, go to SYNC.
    - On a falling edge with `hcnt` < MIN_HIGH: pulse `error`, discard the partial byte, go to SYNC.
    - Otherwise, on a falling edge: bit = (`hcnt` ≥ THRESHOLD_CYCLES). Shift it into `shreg` MSB-first, increment `bitcnt`, go to LOW with `lcnt` = 1.
  - LOW:
    - A rising edge goes to HIGH with `hcnt` = 1.
    - `lcnt` reaching RESET_CYCLES causes a frame end:
      - pulse `frame_end`;
      - if `bitcnt` ≠ 0, also pulse `error` and discard the partial bits;
      - clear `bitcnt` and `byte_index`;
      - go to IDLE.
- When `bitcnt` reaches 8:
  - load `data` from `shreg`, pulse `data_valid` with the current `byte_index`, and clear `bitcnt`;
  - in the following cycle, increment `byte_index`, saturating at 2^IDX_W−1.
- Any return to SYNC clears `bitcnt` and `byte_index`.
- `data_valid` and `frame_end` are never high in the same cycle. A byte completes on a falling edge, so it is always at least RESET_CYCLES before any gap.
- Reset values: `data`=0, `data_valid`=0, `byte_index`=0, `frame_end`=0, `error`=0, `synced`=0, state=SYNC, all counters 0.
- Reset mid-byte discards everything. The receiver must then observe a full RESET_CYCLES low gap before decoding, so a frame in progress when reset deasserts is ignored until its latch.

## Timing
- Synchronizer latency is 2 cycles. Let `din`'s falling edge of bit 8 first be captured at edge N. Then `data_valid` is high in the cycle after edge N+3.
- `hcnt` equals the number of cycles `din` was high, ±1 for asynchronous sampling. Thresholds are compared against `hcnt`.
- `frame_end` is asserted RESET_CYCLES+3 cycles after the last falling edge on `din`, ±1.
- Counter widths are $clog2(RESET_CYCLES+1) for `lcnt` and the SYNC count, and $clog2(MAX_HIGH+2) for `hcnt`.
- No backpressure: consumers must accept a `data_valid` strobe whenever it occurs. The minimum spacing between strobes is 8 bit periods.

## Structure
- Package `ws2812_pkg` holds the 12 MHz timing constants (T0H, T1H, bit period, latch cycles). It is shared with `ws2812_output`; this block's default parameters derive from it.
- Sub-module `sync_2ff` provides the synchronizer and registered previous value (edge detect). It is reusable for other async pins.
- The state machine, counters, shift register and outputs live in `ws2812_input`.

## Test plan
- Frame 0xAC, 0x55, 0x0F (T0H=5, T1H=10, period 15), then 650 low → `data_valid` ×3 with `data` 0xAC/0x55/0x0F and `byte_index` 0/1/2, then one `frame_end`, and no `error`.
- Threshold boundary: highs of exactly 6 and 7 cycles → bits 0 and 1. A byte 0b01010101 built from 6/7 pulses → `data`=0x55.
- A 1-cycle glitch mid-byte → `error` pulse, `synced`=0. No `data_valid` until 600 low cycles, then a clean byte decodes with `byte_index`=0.
- A 20-cycle high → `error` when `hcnt` passes 15, then the SYNC state. A 12-bit frame then a latch gap → one `data_valid`, then `frame_end` together with `error`.
- Reset asserted mid-byte and released mid-frame → no `data_valid` until that frame's latch. The next frame decodes from index 0.
- Loopback `ws2812_output` → `ws2812_input` with 32 LEDs → 96 bytes matching the transmitted values, then `frame_end`.
